// File: rtl/cbus_arbiter.sv
// cbus_arbiter: CPU bus ownership scheduler. The master SH-2 is the parked
// owner; the slave SH-2 and the SCU DMA are granted one at a time, with a
// round-robin tie-break, after the master releases the bus via BRLS_N/BGR_N.
module cbus_arbiter #(
  parameter int unsigned MAX_TENURE = 64
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CE_R,
  input  logic       SSH_REQ_N,
  input  logic       SCU_REQ_N,
  input  logic       BGR_N,
  output logic       BRLS_N,
  output logic       SSH_ACK_N,
  output logic       SCU_ACK_N,
  output logic       PREEMPT_N,
  output logic [1:0] OWNER,
  output logic       ERR
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ_REL,
    S_GRANT,
    S_HANDOFF,
    S_RETURN
  } state_t;

  localparam logic [7:0] TENURE_LIM = 8'(MAX_TENURE);

  state_t     state;
  logic       last_scu;   // LAST pointer: 1 = SCU was granted most recently
  logic [7:0] tenure;

  logic       ssh_req;
  logic       scu_req;
  logic       owner_req;
  logic       other_req;
  logic       pick_scu;
  logic [7:0] tenure_nx;

  // Request decode, round-robin pick and saturating tenure increment
  always_comb begin
    ssh_req   = ~SSH_REQ_N;
    scu_req   = ~SCU_REQ_N;
    // While granted, last_scu names the current owner
    owner_req = last_scu ? scu_req : ssh_req;
    other_req = last_scu ? ssh_req : scu_req;
    // SCU wins when alone, or on a tie when SSH was the last winner
    pick_scu  = scu_req && (!ssh_req || !last_scu);
    tenure_nx = (tenure == 8'hFF) ? tenure : tenure + 8'd1;
  end

  // Ownership FSM with registered pin outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      last_scu  <= 1'b1;
      tenure    <= '0;
      BRLS_N    <= 1'b1;
      SSH_ACK_N <= 1'b1;
      SCU_ACK_N <= 1'b1;
      PREEMPT_N <= 1'b1;
      OWNER     <= 2'd0;
      ERR       <= 1'b0;
    end else if (CE_R) begin
      case (state)
        S_IDLE: begin
          if (ssh_req || scu_req) begin
            BRLS_N <= 1'b0;
            state  <= S_REQ_REL;
          end
        end

        S_REQ_REL: begin
          if (!BGR_N) begin
            if (ssh_req || scu_req) begin
              if (pick_scu) begin
                SCU_ACK_N <= 1'b0;
                OWNER     <= 2'd2;
              end else begin
                SSH_ACK_N <= 1'b0;
                OWNER     <= 2'd1;
              end
              last_scu <= pick_scu;
              tenure   <= '0;
              state    <= S_GRANT;
            end else begin
              state <= S_RETURN;
            end
          end
        end

        S_GRANT: begin
          if (BGR_N) begin
            SSH_ACK_N <= 1'b1;
            SCU_ACK_N <= 1'b1;
            PREEMPT_N <= 1'b1;
            OWNER     <= 2'd0;
            ERR       <= 1'b1;
            state     <= S_RETURN;
          end else if (!owner_req) begin
            SSH_ACK_N <= 1'b1;
            SCU_ACK_N <= 1'b1;
            PREEMPT_N <= 1'b1;
            OWNER     <= 2'd0;
            state     <= other_req ? S_HANDOFF : S_RETURN;
          end else begin
            // Compare against the post-increment count so PREEMPT_N falls
            // exactly MAX_TENURE ticks after the grant tick
            tenure    <= tenure_nx;
            PREEMPT_N <= !((tenure_nx >= TENURE_LIM) && other_req);
          end
        end

        S_HANDOFF: begin
          if (BGR_N) begin
            PREEMPT_N <= 1'b1;
            OWNER     <= 2'd0;
            ERR       <= 1'b1;
            state     <= S_RETURN;
          end else if (other_req) begin
            if (!last_scu) begin
              SCU_ACK_N <= 1'b0;
              OWNER     <= 2'd2;
            end else begin
              SSH_ACK_N <= 1'b0;
              OWNER     <= 2'd1;
            end
            last_scu <= ~last_scu;
            tenure   <= '0;
            state    <= S_GRANT;
          end else begin
            state <= S_RETURN;
          end
        end

        S_RETURN: begin
          BRLS_N <= 1'b1;
          if (BGR_N) state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Scoreboard bench for cbus_arbiter: stimulus queues every expected output
// change with the clock cycle it must appear on; a negedge monitor pops and
// compares whenever the DUT output vector changes.
module tb_cbus_arbiter;

  logic       CLK;
  logic       RST;
  logic       CE_R;
  logic       SSH_REQ_N;
  logic       SCU_REQ_N;
  logic       BGR_N;
  logic       BRLS_N;
  logic       SSH_ACK_N;
  logic       SCU_ACK_N;
  logic       PREEMPT_N;
  logic [1:0] OWNER;
  logic       ERR;

  cbus_arbiter #(.MAX_TENURE(4)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .CE_R      (CE_R),
    .SSH_REQ_N (SSH_REQ_N),
    .SCU_REQ_N (SCU_REQ_N),
    .BGR_N     (BGR_N),
    .BRLS_N    (BRLS_N),
    .SSH_ACK_N (SSH_ACK_N),
    .SCU_ACK_N (SCU_ACK_N),
    .PREEMPT_N (PREEMPT_N),
    .OWNER     (OWNER),
    .ERR       (ERR)
  );

  typedef struct {
    int unsigned cyc;
    logic [6:0]  v;
  } ev_t;

  localparam logic [6:0] RST_VEC = 7'b1111_00_0;

  ev_t         q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  logic        mon_en = 1'b0;
  logic [6:0]  prev;
  logic [6:0]  dvec;
  ev_t         em;

  // Expected output state maintained by the stimulus
  logic       e_brls, e_ssh, e_scu, e_pre, e_err;
  logic [1:0] e_own;

  assign dvec = {BRLS_N, SSH_ACK_N, SCU_ACK_N, PREEMPT_N, OWNER, ERR};

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [6:0] evec();
    return {e_brls, e_ssh, e_scu, e_pre, e_own, e_err};
  endfunction

  task automatic push(input int unsigned d);
    ev_t e;
    e.cyc = cyc + d;
    e.v   = evec();
    q.push_back(e);
  endtask

  task automatic exp_reset();
    e_brls = 1'b1; e_ssh = 1'b1; e_scu = 1'b1; e_pre = 1'b1;
    e_own  = 2'd0; e_err = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Monitor: every output change must match the head of the queue
  always @(negedge CLK) begin
    if (mon_en && dvec !== prev) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change got %b at cyc %0d", dvec, cyc);
      end else begin
        em = q.pop_front();
        if (dvec !== em.v || cyc != em.cyc) begin
          errors++;
          $display("FAIL out_event got %b@%0d want %b@%0d", dvec, cyc, em.v, em.cyc);
        end
      end
      prev = dvec;
    end
  end

  initial begin
    RST = 1'b1; CE_R = 1'b1; SSH_REQ_N = 1'b1; SCU_REQ_N = 1'b1; BGR_N = 1'b1;
    exp_reset();
    #3;
    checks++;
    if (dvec !== RST_VEC) begin
      errors++;
      $display("FAIL reset_state got %b want %b", dvec, RST_VEC);
    end
    @(posedge CLK);
    #4 RST = 1'b0;
    prev   = dvec;
    mon_en = 1'b1;
    step(1);

    // Tie from reset: SSH first, handoff to SCU, SCU preempted, SSH again
    SSH_REQ_N = 1'b0; SCU_REQ_N = 1'b0;
    e_brls = 1'b0; push(1);
    step(1);
    BGR_N = 1'b0;
    e_ssh = 1'b0; e_own = 2'd1; push(1);
    step(3);
    SSH_REQ_N = 1'b1;
    e_ssh = 1'b1; e_own = 2'd0; push(1);
    e_scu = 1'b0; e_own = 2'd2; push(2);
    step(2);
    SSH_REQ_N = 1'b0;
    e_pre = 1'b0; push(4);
    step(5);
    SCU_REQ_N = 1'b1;
    e_scu = 1'b1; e_pre = 1'b1; e_own = 2'd0; push(1);
    e_ssh = 1'b0; e_own = 2'd1; push(2);
    step(2);
    SSH_REQ_N = 1'b1;
    e_ssh = 1'b1; e_own = 2'd0; push(1);
    e_brls = 1'b1; push(2);
    step(2);
    BGR_N = 1'b1;
    step(2);

    // Second tie: SSH won last, so SCU wins now
    SSH_REQ_N = 1'b0; SCU_REQ_N = 1'b0;
    e_brls = 1'b0; push(1);
    step(1);
    BGR_N = 1'b0;
    e_scu = 1'b0; e_own = 2'd2; push(1);
    step(2);
    SSH_REQ_N = 1'b1; SCU_REQ_N = 1'b1;
    e_scu = 1'b1; e_own = 2'd0; push(1);
    e_brls = 1'b1; push(2);
    step(2);
    BGR_N = 1'b1;
    step(2);

    // Single SSH request, release returns the bus to the master
    SSH_REQ_N = 1'b0;
    e_brls = 1'b0; push(1);
    step(2);
    BGR_N = 1'b0;
    e_ssh = 1'b0; e_own = 2'd1; push(1);
    step(4);
    SSH_REQ_N = 1'b1;
    e_ssh = 1'b1; e_own = 2'd0; push(1);
    e_brls = 1'b1; push(2);
    step(2);
    BGR_N = 1'b1;
    step(2);

    // Withdrawal before BGR_N: no ACK, BRLS_N released, ERR stays 0
    SSH_REQ_N = 1'b0;
    e_brls = 1'b0; push(1);
    step(1);
    SSH_REQ_N = 1'b1;
    step(1);
    BGR_N = 1'b0;
    e_brls = 1'b1; push(2);
    step(2);
    BGR_N = 1'b1;
    step(2);

    // Violation: master retakes the bus during an SCU grant
    SCU_REQ_N = 1'b0;
    e_brls = 1'b0; push(1);
    step(1);
    BGR_N = 1'b0;
    e_scu = 1'b0; e_own = 2'd2; push(1);
    step(3);
    BGR_N = 1'b1; SCU_REQ_N = 1'b1;
    e_scu = 1'b1; e_own = 2'd0; e_err = 1'b1; push(1);
    e_brls = 1'b1; push(2);
    step(3);

    // ERR is sticky through a later grant; async reset clears everything
    SSH_REQ_N = 1'b0;
    e_brls = 1'b0; push(1);
    step(1);
    BGR_N = 1'b0;
    e_ssh = 1'b0; e_own = 2'd1; push(1);
    step(2);
    #2;
    RST = 1'b1; SSH_REQ_N = 1'b1; BGR_N = 1'b1;
    exp_reset(); push(0);
    #1;
    checks++;
    if (dvec !== RST_VEC) begin
      errors++;
      $display("FAIL async_reset got %b want %b", dvec, RST_VEC);
    end
    #3 RST = 1'b0;
    step(1);

    // CE_R low for 10 clocks mid-grant freezes the tenure count
    SCU_REQ_N = 1'b0;
    e_brls = 1'b0; push(1);
    step(1);
    BGR_N = 1'b0;
    e_scu = 1'b0; e_own = 2'd2; push(1);
    step(1);
    SSH_REQ_N = 1'b0;
    step(2);
    CE_R = 1'b0;
    step(10);
    CE_R = 1'b1;
    e_pre = 1'b0; push(2);
    step(2);
    SCU_REQ_N = 1'b1;
    e_scu = 1'b1; e_pre = 1'b1; e_own = 2'd0; push(1);
    e_ssh = 1'b0; e_own = 2'd1; push(2);
    step(2);
    SSH_REQ_N = 1'b1;
    e_ssh = 1'b1; e_own = 2'd0; push(1);
    e_brls = 1'b1; push(2);
    step(2);
    BGR_N = 1'b1;
    step(3);

    for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge CLK);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_events got %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
